// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: CPU address decode, bootrom unmap register and OAM DMA engine.
// While a DMA transfer runs the engine owns the shared bus and the CPU is stalled.
module mem_bus_ctrl #(
    parameter int unsigned DMA_LEN  = 160,
    parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_stall,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        rom_cs,
    output logic        wram_cs,
    output logic        wram_we,
    output logic        oam_cs,
    output logic        oam_we,
    input  logic [7:0]  rom_rdata,
    input  logic [7:0]  wram_rdata,
    input  logic [7:0]  oam_rdata,
    output logic        boot_mapped,
    output logic        dma_busy
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    typedef enum logic [2:0] {SEL_NONE, SEL_ROM, SEL_WRAM, SEL_OAM, SEL_DMA, SEL_BOOT} sel_t;

    state_t      state, state_d;
    sel_t        sel_q, sel_d;
    logic [7:0]  count;
    logic [7:0]  dma_src;
    logic [7:0]  dev_rdata;

    logic cpu_in_rom, cpu_in_wram, cpu_in_oam, cpu_in_dma, cpu_in_boot;
    logic src_rom, src_wram, dma_start, last_byte;

    assign cpu_in_rom  = (cpu_addr[15:8] == 8'h00) && boot_mapped;
    assign cpu_in_wram = (cpu_addr >= 16'hC000) && (cpu_addr <= 16'hFDFF);
    assign cpu_in_oam  = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F);
    assign cpu_in_dma  = (cpu_addr == 16'hFF46);
    assign cpu_in_boot = (cpu_addr == 16'hFF50);

    // DMA source decode treats OAM and I/O as unmapped so such pages copy open-bus bytes.
    assign src_rom   = (dma_src == 8'h00) && boot_mapped;
    assign src_wram  = (dma_src >= 8'hC0) && (dma_src <= 8'hFD);
    assign dma_start = (state == IDLE) && cpu_wr && cpu_in_dma;
    assign last_byte = (count == 8'(DMA_LEN - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (dma_start) state_d = RD;
            RD:      state_d = WR;
            WR:      state_d = last_byte ? IDLE : RD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        rom_cs    = 1'b0;
        wram_cs   = 1'b0;
        wram_we   = 1'b0;
        oam_cs    = 1'b0;
        oam_we    = 1'b0;
        dma_busy  = (state != IDLE);
        cpu_stall = (state != IDLE);
        if (rst) begin
            case (state)
                IDLE: begin
                    if (cpu_rd || cpu_wr) mem_addr = cpu_addr;
                    if (cpu_wr)           mem_wdata = cpu_wdata;
                    rom_cs  = cpu_in_rom && cpu_rd && !cpu_wr;
                    wram_cs = cpu_in_wram && (cpu_rd || cpu_wr);
                    wram_we = cpu_in_wram && cpu_wr;
                    oam_cs  = cpu_in_oam && (cpu_rd || cpu_wr);
                    oam_we  = cpu_in_oam && cpu_wr;
                end
                RD: begin
                    mem_addr = {dma_src, count};
                    rom_cs   = src_rom;
                    wram_cs  = src_wram;
                end
                WR: begin
                    mem_addr  = 16'hFE00 + {8'h00, count};
                    mem_wdata = dev_rdata;
                    oam_cs    = 1'b1;
                    oam_we    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // One select register serves both the CPU read return and the DMA fetch.
    always_comb begin
        sel_d = SEL_NONE;
        case (state)
            IDLE: begin
                if (cpu_rd) begin
                    if (cpu_in_rom)       sel_d = SEL_ROM;
                    else if (cpu_in_wram) sel_d = SEL_WRAM;
                    else if (cpu_in_oam)  sel_d = SEL_OAM;
                    else if (cpu_in_dma)  sel_d = SEL_DMA;
                    else if (cpu_in_boot) sel_d = SEL_BOOT;
                end
            end
            RD: begin
                if (src_rom)       sel_d = SEL_ROM;
                else if (src_wram) sel_d = SEL_WRAM;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (sel_q)
            SEL_ROM:  dev_rdata = rom_rdata;
            SEL_WRAM: dev_rdata = wram_rdata;
            SEL_OAM:  dev_rdata = oam_rdata;
            SEL_DMA:  dev_rdata = dma_src;
            SEL_BOOT: dev_rdata = {7'h7F, ~boot_mapped};
            default:  dev_rdata = OPEN_BUS;
        endcase
        cpu_rdata = (state == IDLE) ? dev_rdata : OPEN_BUS;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q       <= SEL_NONE;
            count       <= '0;
            dma_src     <= '0;
            boot_mapped <= 1'b1;
        end else begin
            sel_q <= sel_d;
            if (dma_start) begin
                dma_src <= cpu_wdata;
                count   <= '0;
            end else if (state == WR) begin
                count <= count + 8'd1;
            end
            if ((state == IDLE) && cpu_wr && cpu_in_boot && (cpu_wdata != 8'h00))
                boot_mapped <= 1'b0;
        end
    end

endmodule
